aud_i2s_tx: RTL and testbench

AUD_I2S_TX -- requirements
Module: aud_i2s_tx

---
 rtl/aud_pkg.sv | 16 +
 rtl/aud_clk_div.sv | 63 ++++++
 rtl/aud_i2s_tx.sv | 129 ++++++++++++
 tb/tb_aud_i2s_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared definitions for the audio I2S transmit slice.
//   AUD_DATA_WIDTH : default bits per channel sample
//   AUD_BCK_DIV    : default iCLK cycles per BCK half-period
//   aud_state_e    : transmitter control state encoding
package aud_pkg;

  localparam int unsigned AUD_DATA_WIDTH = 16;
  localparam int unsigned AUD_BCK_DIV    = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } aud_state_e;

endpackage

// File: rtl/aud_clk_div.sv
// Bit-clock divider for the I2S transmitter.
//   clk    : iCLK
//   rst_n  : synchronous active-low reset
//   en     : count enable; counter and BCK hold while low
//   bck_o  : registered BCK level
//   fall_o : high in the cycle whose closing edge drives BCK 1->0
//   rise_o : high in the cycle whose closing edge drives BCK 0->1
module aud_clk_div
  import aud_pkg::*;
#(
  parameter int unsigned BCK_DIV = AUD_BCK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bck_o,
  output logic fall_o,
  output logic rise_o
);

  localparam int unsigned   CW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(BCK_DIV - 1);

  if (BCK_DIV < 2) begin : g_bad_div
    $error("aud_clk_div: BCK_DIV must be at least 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bck_q, bck_d;
  logic          tc;

  assign tc = en && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    bck_d = bck_q;
    if (en) begin
      if (tc) begin
        cnt_d = '0;
        bck_d = ~bck_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      bck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bck_q <= bck_d;
    end
  end

  // Strobes announce the edge about to happen so the serializer can update
  // its registers on the very edge where BCK changes.
  assign bck_o  = bck_q;
  assign fall_o = tc && bck_q;
  assign rise_o = tc && !bck_q;

endmodule

// File: rtl/aud_i2s_tx.sv
// Left-justified, MSB-first stereo DAC serializer.
//   iCLK        : audio control clock
//   iRST_N      : synchronous active-low reset
//   iMUTE       : capture zeros at the next frame boundary
//                 (present only when AUD_I2S_TX_MUTE_EN is defined)
//   iAUD_L/R    : signed left/right samples, captured once per frame
//   oAUD_BCK    : codec bit clock (codec samples on rising edge)
//   oAUD_LRCK   : 1 = left half, 0 = right half
//   oAUD_DATA   : serial data, changes only when BCK falls
//   oSAMPLE_REQ : one-cycle pulse in the cycle a new L/R pair is captured
module aud_i2s_tx
  import aud_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AUD_DATA_WIDTH,
  parameter int unsigned BCK_DIV    = AUD_BCK_DIV
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
`ifdef AUD_I2S_TX_MUTE_EN
  input  logic                  iMUTE,
`endif
  input  logic [DATA_WIDTH-1:0] iAUD_L,
  input  logic [DATA_WIDTH-1:0] iAUD_R,
  output logic                  oAUD_BCK,
  output logic                  oAUD_LRCK,
  output logic                  oAUD_DATA,
  output logic                  oSAMPLE_REQ
);

  localparam int unsigned   FW       = 2 * DATA_WIDTH;
  localparam int unsigned   BW       = $clog2(FW);
  localparam logic [BW-1:0] LAST_BIT = BW'(FW - 1);
  localparam logic [BW-1:0] HALF     = BW'(DATA_WIDTH);

  if (BCK_DIV < 2 || DATA_WIDTH < 2) begin : g_bad_param
    $error("aud_i2s_tx: BCK_DIV and DATA_WIDTH must both be at least 2");
  end

  aud_state_e    state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          primed_q, primed_d;
  logic          lrck_q, lrck_d;
  logic          data_q, data_d;
  logic          req_q, req_d;
  logic [FW-1:0] sh_q, sh_d;

  logic div_en;
  logic bck_fall;
  logic bck_rise_unused;
  logic mute;

`ifdef AUD_I2S_TX_MUTE_EN
  assign mute = iMUTE;
`else
  assign mute = 1'b0;
`endif

  assign div_en = (state_q != ST_IDLE);

  aud_clk_div #(
    .BCK_DIV (BCK_DIV)
  ) u_clk_div (
    .clk    (iCLK),
    .rst_n  (iRST_N),
    .en     (div_en),
    .bck_o  (oAUD_BCK),
    .fall_o (bck_fall),
    .rise_o (bck_rise_unused)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    primed_d  = primed_q;
    lrck_d    = lrck_q;
    data_d    = data_q;
    req_d     = 1'b0;
    sh_d      = sh_q;

    case (state_q)
      ST_IDLE:  state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase

    if (bck_fall) begin
      // The very first fall after START is a frame boundary even though the
      // bit counter already reads zero; primed_q distinguishes it from bit 0.
      if (!primed_q || (bit_cnt_q == LAST_BIT)) begin
        bit_cnt_d = '0;
        primed_d  = 1'b1;
        lrck_d    = 1'b1;
        req_d     = 1'b1;
        sh_d      = mute ? '0 : {iAUD_L, iAUD_R};
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        lrck_d    = (bit_cnt_d < HALF);
        sh_d      = sh_q << 1;
      end
      data_d = sh_d[FW-1];
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      primed_q  <= 1'b0;
      lrck_q    <= 1'b0;
      data_q    <= 1'b0;
      req_q     <= 1'b0;
      sh_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      primed_q  <= primed_d;
      lrck_q    <= lrck_d;
      data_q    <= data_d;
      req_q     <= req_d;
      sh_q      <= sh_d;
    end
  end

  assign oAUD_LRCK   = lrck_q;
  assign oAUD_DATA   = data_q;
  assign oSAMPLE_REQ = req_q;

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Self-checking bench for aud_i2s_tx at default parameters.
// A timing model derived from the frame arithmetic predicts every output on
// every cycle; directed checks pin latency, periods and recovered words.
module tb_aud_i2s_tx;

  localparam int DW  = 16;
  localparam int DIV = 6;
  localparam int HB  = 2 * DIV;     // iCLK per bit
  localparam int FR  = HB * 2 * DW; // iCLK per frame

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mute_drv = 1'b0;
  logic [15:0] l_drv = 16'hA5C3;
  logic [15:0] r_drv = 16'h3C5A;
  logic        o_bck, o_lrck, o_data, o_req;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aud_i2s_tx #(
    .DATA_WIDTH (DW),
    .BCK_DIV    (DIV)
  ) dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
`ifdef AUD_I2S_TX_MUTE_EN
    .iMUTE       (mute_drv),
`endif
    .iAUD_L      (l_drv),
    .iAUD_R      (r_drv),
    .oAUD_BCK    (o_bck),
    .oAUD_LRCK   (o_lrck),
    .oAUD_DATA   (o_data),
    .oSAMPLE_REQ (o_req)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // t = iCLK edges since START (START edge is t=0), -1 while in reset.
  // Frames start at t = HB + k*FR; bit b of the frame occupies HB cycles.
  int          t = -1;
  int          cyc = 0;
  logic [31:0] word = '0;
  logic        model_valid = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    model_valid <= 1'b1;
    if (!rst_n) begin
      t <= -1;
    end else begin
      t <= t + 1;
      if ((t + 1 >= HB) && (((t + 1 - HB) % FR) == 0))
        word <= mute_drv ? 32'h0 : {l_drv, r_drv};
    end
  end

  // returns {bck, lrck, data, req}
  function automatic logic [3:0] model_out(input int tt, input logic [31:0] w);
    int n;
    int b;
    logic [3:0] r;
    r = '0;
    if (tt >= 0) r[3] = ((tt / DIV) % 2) == 1;
    if (tt >= HB) begin
      n = (tt - HB) / HB;
      b = n % (2 * DW);
      r[2] = (b < DW);
      r[1] = w[2*DW-1-b];
      r[0] = ((tt - HB) % FR) == 0;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (model_valid) begin
      chk("m_bck",  {31'b0, o_bck},  {31'b0, model_out(t, word)[3]});
      chk("m_lrck", {31'b0, o_lrck}, {31'b0, model_out(t, word)[2]});
      chk("m_data", {31'b0, o_data}, {31'b0, model_out(t, word)[1]});
      chk("m_req",  {31'b0, o_req},  {31'b0, model_out(t, word)[0]});
    end
  end

  // ---------------- deserializer / period monitor ----------------
  logic        bck_prev = 1'b0, lrck_prev = 1'b0;
  logic [15:0] lacc = '0, racc = '0, last_left = '0, last_right = '0;
  int          bck_rise_last = 0, bck_rise_prev = 0;
  int          lrck_rise_last = 0, lrck_rise_prev = 0;

  always @(negedge clk) begin
    bck_prev  <= (o_bck === 1'b1);
    lrck_prev <= (o_lrck === 1'b1);
    if (o_bck === 1'b1 && !bck_prev) begin
      bck_rise_prev <= bck_rise_last;
      bck_rise_last <= cyc;
      if (o_lrck === 1'b1) lacc <= {lacc[14:0], o_data};
      else                 racc <= {racc[14:0], o_data};
    end
    if (o_lrck === 1'b1 && !lrck_prev) begin
      lrck_rise_prev <= lrck_rise_last;
      lrck_rise_last <= cyc;
      last_right     <= racc;
    end
    if (o_lrck === 1'b0 && lrck_prev) last_left <= lacc;
  end

  // ---------------- directed helpers ----------------
  task automatic wait_req(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (o_req === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s sample_req timeout actual=none required=pulse", name);
    end
  endtask

  // Waits for the next frame boundary, then checks the words just completed.
  task automatic frame_done(input string name, input logic [15:0] el, input logic [15:0] er);
    wait_req(name);
    @(negedge clk);
    chk({name, "_L"}, {16'h0, last_left},  {16'h0, el});
    chk({name, "_R"}, {16'h0, last_right}, {16'h0, er});
  endtask

  // Called on the negedge where reset is released; expects first REQ 12 after START.
  task automatic measure_latency(input string name);
    int lat;
    lat = -1;
    for (int i = 0; i < 100 && lat < 0; i++) begin
      @(negedge clk);
      if (o_req === 1'b1) lat = i;
    end
    chk(name, lat, 12);
  endtask

  logic [15:0] new_l [3] = '{16'h0FFF, 16'h0000, 16'h0FFF};
  logic [15:0] new_r [3] = '{16'h1234, 16'h8001, 16'h3C5A};

  initial begin
    logic [15:0] pl, pr;
    int nreq;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {28'h0, o_bck, o_lrck, o_data, o_req}, 32'h0);
    rst_n = 1'b1;
    measure_latency("first_req_latency");

    frame_done("frame0", 16'hA5C3, 16'h3C5A);
    chk("bck_period",  bck_rise_last - bck_rise_prev, 12);
    chk("lrck_period", lrck_rise_last - lrck_rise_prev, 384);

    // Mid-frame input changes only show up in the following frame.
    pl = 16'hA5C3;
    pr = 16'h3C5A;
    for (int i = 0; i < 3; i++) begin
      repeat (100) @(negedge clk);
      l_drv = new_l[i];
      r_drv = new_r[i];
      frame_done("midframe", pl, pr);
      pl = new_l[i];
      pr = new_r[i];
    end
    frame_done("midframe_last", pl, pr);

    // Ten frames: exactly ten one-cycle request pulses.
    nreq = 0;
    repeat (3840) begin
      @(negedge clk);
      if (o_req === 1'b1) nreq++;
    end
    chk("req_10frames", nreq, 10);

    // Reset for one cycle at bit count 20.
    wait_req("pre_bit20");
    repeat (20 * HB) @(negedge clk);
    chk("bit20_lrck", {31'b0, o_lrck}, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("bit20_reset_outputs", {28'h0, o_bck, o_lrck, o_data, o_req}, 32'h0);
    rst_n = 1'b1;
    measure_latency("restart_latency");
    frame_done("restart_frame", pl, pr);

`ifdef AUD_I2S_TX_MUTE_EN
    l_drv = 16'h7FFF;
    mute_drv = 1'b1;
    frame_done("mute_late", pl, pr);
    mute_drv = 1'b0;
    frame_done("mute_zero", 16'h0000, 16'h0000);
    repeat (100) @(negedge clk);
    mute_drv = 1'b1;
    frame_done("mute_midframe", 16'h7FFF, pr);
    mute_drv = 1'b0;
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
